// File: rtl/vga_pattern_gen_if.sv
// Pixel stream between the VGA timing block and the pattern generator.
//   next_x, next_y : look-ahead coordinate of the pixel displayed next (timing -> pattern)
//   color_in       : RGB332 colour for that coordinate, one cycle later (pattern -> timing)
// Stream semantics: there is no valid/ready pair. A coordinate is presented on every
// pixel clock and is always accepted, and its colour is returned exactly one cycle later.
interface vga_pattern_gen_if;
  logic [9:0] next_x;
  logic [9:0] next_y;
  logic [7:0] color_in;

  modport master (output next_x, output next_y, input color_in);
  modport slave  (input next_x, input next_y, output color_in);
endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source for the VGA timing stage.
// Four patterns: colour bars, checkerboard (inverts every 32 frames), bouncing box,
// and a solid colour equal to the frame counter. Mode changes and animation are applied
// once per frame, in the first blanking line, so the visible image never tears.
// Ports:
//   clock_25   : pixel clock, the only clock
//   rst        : asynchronous active-low reset
//   pix        : pixel stream (next_x/next_y in, color_in out, registered)
//   mode_btn   : single-cycle pulse, advances the pending mode
//   mode       : currently displayed mode
//   frame_tick : combinational one-cycle pulse at the frame update point
//   frame_cnt  : frame counter, wraps 255 -> 0
module vga_pattern_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BAR_WIDTH = 80,
  parameter int BOX_SIZE  = 32
) (
  input  logic               clock_25,
  input  logic               rst,
  vga_pattern_gen_if.slave   pix,
  input  logic               mode_btn,
  output logic [1:0]         mode,
  output logic               frame_tick,
  output logic [7:0]         frame_cnt
);

  // All coordinate arithmetic is 11 bits wide so box_x + BOX_SIZE cannot wrap.
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
  localparam logic [10:0] BOX   = 11'(BOX_SIZE);
  localparam logic [10:0] XMAX  = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] YMAX  = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] B1    = 11'(BAR_WIDTH * 1);
  localparam logic [10:0] B2    = 11'(BAR_WIDTH * 2);
  localparam logic [10:0] B3    = 11'(BAR_WIDTH * 3);
  localparam logic [10:0] B4    = 11'(BAR_WIDTH * 4);
  localparam logic [10:0] B5    = 11'(BAR_WIDTH * 5);
  localparam logic [10:0] B6    = 11'(BAR_WIDTH * 6);
  localparam logic [10:0] B7    = 11'(BAR_WIDTH * 7);

  logic [1:0]  mode_pend;
  logic [9:0]  box_x;
  logic [9:0]  box_y;
  logic        dx;
  logic        dy;
  logic [10:0] x;
  logic [10:0] y;
  logic [10:0] bx;
  logic [10:0] by;
  logic        active;
  logic        in_box;
  logic [7:0]  bar_color;
  logic [7:0]  pix_color;

  assign x  = {1'b0, pix.next_x};
  assign y  = {1'b0, pix.next_y};
  assign bx = {1'b0, box_x};
  assign by = {1'b0, box_y};

  // First pixel of the first blanking line: happens once per frame.
  assign frame_tick = (y == V_ACT) && (pix.next_x == 10'd0);
  assign active     = (x < H_ACT) && (y < V_ACT);
  assign in_box     = (x >= bx) && (x < bx + BOX) && (y >= by) && (y < by + BOX);

  // Bar index by comparator chain rather than a divider.
  always_comb begin
    bar_color = 8'h00;
    if      (x < B1) bar_color = 8'hFF;
    else if (x < B2) bar_color = 8'hFC;
    else if (x < B3) bar_color = 8'h1F;
    else if (x < B4) bar_color = 8'h1C;
    else if (x < B5) bar_color = 8'hE3;
    else if (x < B6) bar_color = 8'hE0;
    else if (x < B7) bar_color = 8'h03;
    else             bar_color = 8'h00;
  end

  always_comb begin
    pix_color = 8'h00;
    if (active) begin
      case (mode)
        2'd0:    pix_color = bar_color;
        2'd1:    pix_color = (pix.next_x[5] ^ pix.next_y[5] ^ frame_cnt[5]) ? 8'hFF : 8'h00;
        2'd2:    pix_color = in_box ? 8'hE0 : 8'h03;
        default: pix_color = frame_cnt;
      endcase
    end
  end

  always_ff @(posedge clock_25 or negedge rst) begin
    if (!rst) begin
      pix.color_in <= 8'h00;
    end else begin
      pix.color_in <= pix_color;
    end
  end

  // Button presses accumulate in mode_pend; the tick copies the pre-increment
  // value, so a press on the tick cycle is applied at the following tick.
  always_ff @(posedge clock_25 or negedge rst) begin
    if (!rst) begin
      mode_pend <= 2'd0;
      mode      <= 2'd0;
      frame_cnt <= 8'd0;
    end else begin
      mode_pend <= mode_pend + 2'(mode_btn);
      if (frame_tick) begin
        mode      <= mode_pend;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Box bounces: at a limit the direction flips and the box steps back inward
  // in the same tick, so it never dwells on an edge for two frames.
  always_ff @(posedge clock_25 or negedge rst) begin
    if (!rst) begin
      box_x <= 10'd0;
      box_y <= 10'd0;
      dx    <= 1'b1;
      dy    <= 1'b1;
    end else if (frame_tick) begin
      if (dx && (bx == XMAX)) begin
        dx    <= 1'b0;
        box_x <= 10'(XMAX - 11'd1);
      end else if (!dx && (box_x == 10'd0)) begin
        dx    <= 1'b1;
        box_x <= 10'd1;
      end else begin
        box_x <= dx ? box_x + 10'd1 : box_x - 10'd1;
      end

      if (dy && (by == YMAX)) begin
        dy    <= 1'b0;
        box_y <= 10'(YMAX - 11'd1);
      end else if (!dy && (box_y == 10'd0)) begin
        dy    <= 1'b1;
        box_y <= 10'd1;
      end else begin
        box_y <= dy ? box_y + 10'd1 : box_y - 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
module tb_vga_pattern_gen;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic       mode_btn;
  logic [1:0] mode;
  logic       frame_tick;
  logic [7:0] frame_cnt;
  int         checks;
  int         errors;
  int         ticks;

  vga_pattern_gen_if pix ();

  vga_pattern_gen dut (
    .clock_25   (clk),
    .rst        (rst),
    .pix        (pix),
    .mode_btn   (mode_btn),
    .mode       (mode),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference colour for the bar pattern, written independently as a table.
  function automatic logic [7:0] bar_ref(input int px);
    logic [7:0] tbl [0:7];
    tbl = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
    if (px >= 640) return 8'h00;
    return tbl[px / 80];
  endfunction

  // ---------------- driver tasks ----------------
  // Present a coordinate, then sample the colour one edge later.
  task automatic pix_at(input int px, input int py, input logic [7:0] exp, input string tag);
    @(negedge clk);
    pix.next_x = 10'(px);
    pix.next_y = 10'(py);
    @(negedge clk);
    check(tag, {8'h00, pix.color_in}, {8'h00, exp});
  endtask

  task automatic ft_at(input int px, input int py, input logic exp, input string tag);
    @(negedge clk);
    pix.next_x = 10'(px);
    pix.next_y = 10'(py);
    #1;
    check(tag, {15'd0, frame_tick}, {15'd0, exp});
  endtask

  task automatic press();
    @(negedge clk);
    pix.next_x = 10'd5;
    pix.next_y = 10'd5;
    mode_btn   = 1'b1;
    @(negedge clk);
    mode_btn   = 1'b0;
  endtask

  // One frame update: drive the tick coordinate for exactly one edge.
  task automatic tick(input logic btn);
    @(negedge clk);
    pix.next_x = 10'd0;
    pix.next_y = 10'd480;
    mode_btn   = btn;
    #1;
    check("frame_tick_high", {15'd0, frame_tick}, 16'd1);
    @(negedge clk);
    pix.next_x = 10'd0;
    pix.next_y = 10'd481;
    mode_btn   = 1'b0;
    ticks++;
  endtask

  task automatic ticks_to(input int n);
    while (ticks < n) tick(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    ticks = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    ticks      = 0;
    rst        = 1'b0;
    mode_btn   = 1'b0;
    pix.next_x = 10'd0;
    pix.next_y = 10'd481;
    repeat (3) @(negedge clk);
    check("reset_color", {8'h00, pix.color_in}, 16'h0000);
    check("reset_mode", {14'd0, mode}, 16'd0);
    check("reset_frame_cnt", {8'h00, frame_cnt}, 16'd0);
    rst = 1'b1;
    pix_at(0, 0, 8'hFF, "post_reset_px00");

    // Colour bar sweep, pipelined: each sample reflects the previous coordinate.
    for (int i = 0; i <= 800; i++) begin
      @(negedge clk);
      if (i > 0) check("bars", {8'h00, pix.color_in}, {8'h00, bar_ref(i - 1)});
      pix.next_x = 10'(i % 800);
      pix.next_y = 10'd10;
    end
    pix_at(1, 480, 8'h00, "blank_m0_y480");
    pix_at(5, 524, 8'h00, "blank_m0_y524");
    pix_at(700, 10, 8'h00, "blank_m0_x700");

    ft_at(1, 480, 1'b0, "frame_tick_x1");
    ft_at(0, 479, 1'b0, "frame_tick_y479");
    ft_at(0, 481, 1'b0, "frame_tick_y481");

    // Mode accumulation: three presses in-frame plus one on the tick.
    press(); press(); press();
    tick(1'b1);
    check("mode_after_tick1", {14'd0, mode}, 16'd3);
    check("frame_cnt_tick1", {8'h00, frame_cnt}, 16'd1);
    tick(1'b0);
    check("mode_after_tick2", {14'd0, mode}, 16'd0);
    repeat (5) press();
    tick(1'b0);
    check("mode_five_presses", {14'd0, mode}, 16'd1);
    check("frame_cnt_tick3", {8'h00, frame_cnt}, 16'd3);

    // Checkerboard, frame_cnt = 3 (bit 5 clear).
    pix_at(0, 0, 8'h00, "chk_00");
    pix_at(32, 0, 8'hFF, "chk_32_0");
    pix_at(0, 32, 8'hFF, "chk_0_32");
    pix_at(32, 32, 8'h00, "chk_32_32");
    pix_at(32, 500, 8'h00, "blank_m1");
    ticks_to(32);
    check("frame_cnt_32", {8'h00, frame_cnt}, 16'd32);
    pix_at(0, 0, 8'hFF, "chk_inv_00");
    pix_at(32, 0, 8'h00, "chk_inv_32_0");

    // Solid colour from frame counter.
    do_reset();
    press(); press(); press();
    tick(1'b0);
    check("mode_solid", {14'd0, mode}, 16'd3);
    pix_at(100, 100, 8'h01, "solid_1");
    ticks_to(255);
    pix_at(100, 100, 8'hFF, "solid_255");
    pix_at(100, 480, 8'h00, "blank_m3_y480");
    pix_at(700, 10, 8'h00, "blank_m3_x700");
    tick(1'b0);
    check("frame_cnt_wrap", {8'h00, frame_cnt}, 16'd0);
    pix_at(100, 100, 8'h00, "solid_wrap");
    tick(1'b0);
    pix_at(100, 100, 8'h01, "solid_after_wrap");

    // Asynchronous reset mid-line, checked before any further clock edge.
    pix.next_x = 10'd100;
    pix.next_y = 10'd100;
    @(negedge clk);
    check("pre_async_color", {8'h00, pix.color_in}, 16'h0001);
    #3 rst = 1'b0;
    #1;
    check("async_color", {8'h00, pix.color_in}, 16'h0000);
    check("async_mode", {14'd0, mode}, 16'd0);
    check("async_frame_cnt", {8'h00, frame_cnt}, 16'd0);
    @(negedge clk);
    rst   = 1'b1;
    ticks = 0;
    pix_at(0, 0, 8'hFF, "post_async_px00");

    // Bouncing box.
    press(); press();
    tick(1'b0);
    check("mode_box", {14'd0, mode}, 16'd2);
    pix_at(1, 1, 8'hE0, "box1_in");
    pix_at(0, 1, 8'h03, "box1_left");
    pix_at(33, 1, 8'h03, "box1_right");
    pix_at(32, 32, 8'hE0, "box1_corner");
    pix_at(32, 33, 8'h03, "box1_below");
    ticks_to(448);
    pix_at(448, 448, 8'hE0, "box448_in");
    pix_at(448, 447, 8'h03, "box448_above");
    pix_at(479, 479, 8'hE0, "box448_corner");
    tick(1'b0);
    pix_at(449, 447, 8'hE0, "box449_in");
    pix_at(449, 479, 8'h03, "box449_below");
    ticks_to(608);
    pix_at(608, 288, 8'hE0, "box608_in");
    pix_at(607, 288, 8'h03, "box608_left");
    pix_at(639, 319, 8'hE0, "box608_corner");
    tick(1'b0);
    pix_at(607, 287, 8'hE0, "box609_in");
    pix_at(639, 287, 8'h03, "box609_right");
    tick(1'b0);
    pix_at(606, 286, 8'hE0, "box610_in");
    pix_at(638, 286, 8'h03, "box610_right");
    pix_at(605, 286, 8'h03, "box610_left");
    check("frame_cnt_610", {8'h00, frame_cnt}, 16'd98);
    pix_at(606, 480, 8'h00, "blank_m2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
